// File: rtl/zombie_spawner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zombie_spawner - Punch Zombie game core: picks holes, judges presses, score |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module zombie_spawner #(
  parameter int         SHOW_CYCLES = 25_000_000,
  parameter int         GAP_CYCLES  = 12_500_000,
  parameter int         MAX_MISS    = 3,
  parameter int         SCORE_W     = 8,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:1]         btn,
  output logic [3:1]         led,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         miss,
  output logic               hit,
  output logic               game_over
);

  localparam int TIMER_W = $clog2((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES);
  localparam logic [TIMER_W-1:0] SHOW_LOAD  = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [2:0]         MISS_LIMIT = 3'(MAX_MISS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         lfsr;
  logic               start_q;
  logic [3:1]         btn_q;

  logic               start_edge;
  logic [3:1]         btn_edge;
  logic               wrong_press;
  logic               right_press;
  logic               timeout;
  logic [2:0]         miss_next;
  logic [SCORE_W-1:0] score_next;
  logic [3:1]         hole_led;

  assign start_edge = start & ~start_q;
  assign btn_edge   = btn & ~btn_q;
  // While showing, led itself is the latched one-hot hole.
  assign wrong_press = |(btn_edge & ~led);
  assign right_press = |(btn_edge & led);
  assign timeout     = (timer == '0);
  assign miss_next   = miss + 3'd1;
  assign score_next  = (&score) ? score : score + SCORE_W'(1);

  always_comb begin
    hole_led = 3'b001;
    case (lfsr[1:0])
      2'b01:   hole_led = 3'b010;
      2'b10:   hole_led = 3'b100;
      default: hole_led = 3'b001;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      lfsr      <= LFSR_SEED;
      start_q   <= 1'b0;
      btn_q     <= 3'b000;
      led       <= 3'b000;
      score     <= '0;
      miss      <= 3'd0;
      hit       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      start_q <= start;
      btn_q   <= btn;
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      hit     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            score <= '0;
            miss  <= 3'd0;
            timer <= GAP_LOAD;
            state <= GAP;
          end
        end
        GAP: begin
          if (timeout) begin
            led   <= hole_led;
            timer <= SHOW_LOAD;
            state <= SHOW;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        SHOW: begin
          // A wrong press beats a simultaneous right one; a hit beats the timeout.
          if (wrong_press || (!right_press && timeout)) begin
            miss  <= miss_next;
            timer <= GAP_LOAD;
            if (miss_next == MISS_LIMIT) begin
              led       <= 3'b111;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              led   <= 3'b000;
              state <= GAP;
            end
          end else if (right_press) begin
            score <= score_next;
            hit   <= 1'b1;
            led   <= 3'b000;
            timer <= GAP_LOAD;
            state <= GAP;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        OVER: begin
          if (start_edge) begin
            score     <= '0;
            miss      <= 3'd0;
            game_over <= 1'b0;
            led       <= 3'b000;
            timer     <= GAP_LOAD;
            state     <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zombie_spawner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_zombie_spawner - directed and random checks against a game-rule model    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_zombie_spawner;

  localparam int SHOW = 8;
  localparam int GAP  = 4;
  localparam int MAXM = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:1] btn = 3'b000;

  logic [3:1] led, led_s;
  logic [7:0] score;
  logic [1:0] score_s;
  logic [2:0] miss, miss_s;
  logic       hit, hit_s, game_over, game_over_s;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 gap, 2 show, 3 over; m_left = edges until phase ends
  int       m_phase, m_left, m_hole, m_score, m_miss;
  bit       m_hit, m_start_prev;
  bit [3:1] m_btn_prev;
  bit [7:0] m_lfsr;

  zombie_spawner #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .MAX_MISS(MAXM), .SCORE_W(8),
                   .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .led(led), .score(score),
    .miss(miss), .hit(hit), .game_over(game_over));

  zombie_spawner #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .MAX_MISS(MAXM), .SCORE_W(2),
                   .LFSR_SEED(SEED)) dut_s (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .led(led_s), .score(score_s),
    .miss(miss_s), .hit(hit_s), .game_over(game_over_s));

  always #5 clk = ~clk;

  function automatic bit [7:0] next_lfsr(bit [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int hole_of(bit [7:0] v);
    case (v % 4)
      1:       return 2;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [3:1] lit_of(int h);
    return 3'(1 << (h - 1));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_hole = 1; m_score = 0; m_miss = 0;
    m_hit = 0; m_start_prev = 0; m_btn_prev = 3'b000; m_lfsr = SEED;
  endtask

  task automatic model_miss();
    m_miss++;
    m_phase = (m_miss == MAXM) ? 3 : 1;
    m_left  = GAP;
  endtask

  task automatic model_step();
    bit       s_edge;
    bit [3:1] b_edge, lit;
    bit [7:0] cur;
    s_edge = start && !m_start_prev;
    b_edge = btn & ~m_btn_prev;
    m_start_prev = start;
    m_btn_prev = btn;
    cur = m_lfsr;
    m_lfsr = next_lfsr(cur);
    m_hit = 0;
    lit = lit_of(m_hole);
    case (m_phase)
      0, 3: if (s_edge) begin
        m_score = 0; m_miss = 0; m_phase = 1; m_left = GAP;
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2; m_hole = hole_of(cur); m_left = SHOW;
        end
      end
      default: begin
        if ((b_edge & ~lit) != 0) model_miss();
        else if ((b_edge & lit) != 0) begin
          m_score++; m_hit = 1; m_phase = 1; m_left = GAP;
        end else begin
          m_left--;
          if (m_left == 0) model_miss();
        end
      end
    endcase
  endtask

  task automatic check_all();
    logic [3:1] exp_led;
    exp_led = (m_phase == 2) ? lit_of(m_hole) : (m_phase == 3) ? 3'b111 : 3'b000;
    chk("led", led, exp_led);
    chk("score", score, (m_score > 255) ? 255 : m_score);
    chk("miss", miss, m_miss);
    chk("hit", hit, m_hit);
    chk("game_over", game_over, m_phase == 3);
    chk("led_w2", led_s, exp_led);
    chk("score_w2", score_s, (m_score > 3) ? 3 : m_score);
    chk("miss_w2", miss_s, m_miss);
    chk("hit_w2", hit_s, m_hit);
    chk("game_over_w2", game_over_s, m_phase == 3);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asserted away from a clock edge so the outputs must clear asynchronously.
  task automatic do_reset();
    start = 1'b0;
    btn = 3'b000;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Runs until a zombie lights, restarting the game if it sits idle or over.
  task automatic wait_show();
    int n = 0;
    while (m_phase != 2 && n < 100) begin
      if (m_phase == 0 || m_phase == 3) pulse_start();
      else cycle();
      n++;
    end
    chk("show_reached", (led != 3'b000) && (led != 3'b111), 1);
  endtask

  initial begin
    int h;
    int n;
    bit found;

    #2;
    do_reset();
    repeat (20) cycle();
    chk("idle_led", led, 0);

    // No presses: three timeouts end the game
    pulse_start();
    n = 0;
    while (m_phase != 3 && n < 80) begin cycle(); n++; end
    chk("over_led", led, 3'b111);
    chk("over_flag", game_over, 1);
    chk("over_miss", miss, 3);

    // Hit on an early show cycle, then presses during the gap
    pulse_start();
    chk("restart_miss", miss, 0);
    chk("restart_go", game_over, 0);
    wait_show();
    cycle();
    btn = lit_of(m_hole);
    cycle();
    chk("hit_pulse", hit, 1);
    chk("hit_score", score, 1);
    chk("hit_led", led, 0);
    btn = 3'b000;
    cycle();
    chk("hit_fall", hit, 0);
    btn = 3'b111;
    cycle();
    btn = 3'b000;
    chk("gap_press_miss", miss, 0);
    chk("gap_press_score", score, 1);
    cycle();
    chk("gap_dark", led, 0);
    cycle();
    chk("relight", led, lit_of(m_hole));

    // Lit and unlit buttons on the same edge count as a miss
    btn = lit_of(m_hole) | lit_of(m_hole % 3 + 1);
    cycle();
    btn = 3'b000;
    chk("both_miss", miss, 1);
    chk("both_score", score, 1);
    chk("both_hit", hit, 0);

    // A press on the final show cycle is still a hit
    wait_show();
    repeat (SHOW - 1) cycle();
    btn = lit_of(m_hole);
    cycle();
    btn = 3'b000;
    chk("last_hit", hit, 1);
    chk("last_miss", miss, 1);
    chk("last_score", score, 2);

    // Button held across two zombies in the same hole counts once
    found = 0;
    for (int a = 0; a < 40 && !found; a++) begin
      wait_show();
      h = m_hole;
      btn = lit_of(h);
      cycle();
      chk("hold_first", hit, 1);
      wait_show();
      if (m_hole == h) begin
        found = 1;
        repeat (3) cycle();
        chk("hold_still_lit", led, lit_of(h));
      end
      btn = 3'b000;
      cycle();
    end
    chk("hold_found", found, 1);

    // Five straight hits: narrow score saturates
    for (int k = 0; k < 5; k++) begin
      wait_show();
      btn = lit_of(m_hole);
      cycle();
      btn = 3'b000;
      cycle();
    end
    chk("sat_score_w2", score_s, 3);
    n = 0;
    while (m_phase != 3 && n < 100) begin cycle(); n++; end
    chk("sat_over", game_over, 1);
    pulse_start();
    chk("over_restart_score", score, 0);
    chk("over_restart_miss", miss, 0);
    chk("over_restart_go", game_over, 0);
    repeat (GAP - 1) cycle();
    chk("over_restart_dark", led, 0);
    cycle();
    chk("over_restart_lit", led, lit_of(m_hole));

    // Reset in the middle of a show
    repeat (2) cycle();
    do_reset();
    chk("midreset_led", led, 0);
    repeat (5) cycle();

    // Random play
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) btn = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
